// File: rtl/sar_decision_logic.sv
// SAR decision logic: resolves an N-bit code MSB-first from comparator decisions, with a no-decision watchdog.
// Define SAR_MAJ3_EN to resolve each bit by a majority of three decisions.
module sar_decision_logic #(
  parameter int N       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         dec_valid,
  input  logic         decision,
  output logic [N-1:0] dac_code,
  output logic         cmp_req,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int IDX_W = $clog2(N);
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_bit_idx;
  logic [7:0]       r_wdog;
  logic [N-1:0]     r_dac_code;
  logic [N-1:0]     r_result;
  logic             r_cmp_req;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic [N-1:0]     w_bit_mask;
  logic [N-1:0]     w_next_mask;
  logic [N-1:0]     w_resolved;
  logic             w_keep;
  logic             w_resolve;
  logic             w_timeout;

  assign w_bit_mask  = N'(1) << r_bit_idx;
  assign w_next_mask = N'(1) << (r_bit_idx - IDX_W'(1));
  assign w_resolved  = w_keep ? r_dac_code : (r_dac_code & ~w_bit_mask);
  assign w_timeout   = !dec_valid && (r_wdog == WDOG_LAST);

`ifdef SAR_MAJ3_EN
  logic [1:0] r_vote;
  logic [1:0] r_ones;
  logic [1:0] w_ones_tot;

  assign w_ones_tot = r_ones + {1'b0, decision};
  assign w_keep     = (w_ones_tot >= 2'd2);
  assign w_resolve  = dec_valid && (r_vote == 2'd2);

  // Vote state lives only while a bit is being resolved in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vote <= 2'd0;
      r_ones <= 2'd0;
    end else if (r_state != S_WAIT) begin
      r_vote <= 2'd0;
      r_ones <= 2'd0;
    end else if (dec_valid) begin
      if (r_vote == 2'd2) begin
        r_vote <= 2'd0;
        r_ones <= 2'd0;
      end else begin
        r_vote <= r_vote + 2'd1;
        r_ones <= w_ones_tot;
      end
    end else if (w_timeout) begin
      r_vote <= 2'd0;
      r_ones <= 2'd0;
    end
  end
`else
  assign w_keep    = decision;
  assign w_resolve = dec_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bit_idx  <= '0;
      r_wdog     <= 8'd0;
      r_dac_code <= '0;
      r_result   <= '0;
      r_cmp_req  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_dac_code <= N'(1) << (N - 1);
            r_bit_idx  <= IDX_W'(N - 1);
            r_wdog     <= 8'd0;
            r_err      <= 1'b0;
            r_busy     <= 1'b1;
            r_cmp_req  <= 1'b1;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // An accepted decision always beats a watchdog expiring on the same edge
          if (dec_valid) begin
            r_wdog <= 8'd0;
            if (w_resolve) begin
              if (r_bit_idx != '0) begin
                r_dac_code <= w_resolved | w_next_mask;
                r_bit_idx  <= r_bit_idx - IDX_W'(1);
              end else begin
                r_dac_code <= w_resolved;
                r_result   <= w_resolved;
                r_done     <= 1'b1;
                r_busy     <= 1'b0;
                r_cmp_req  <= 1'b0;
                r_state    <= S_DONE;
              end
            end
          end else if (w_timeout) begin
            r_err     <= 1'b1;
            r_result  <= '0;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_cmp_req <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_wdog <= r_wdog + 8'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dac_code = r_dac_code;
  assign cmp_req  = r_cmp_req;
  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign err      = r_err;

endmodule
